// File: rtl/pc_fetch_pkg.sv
// Shared constants, FSM encoding and fetch-entry type for the LA32 PC/IF stage.
package pc_fetch_pkg;

  localparam logic [6:0]  ECODE_INT    = 7'h00;
  localparam logic [6:0]  ECODE_ADEF   = 7'h08;
  localparam logic [31:0] NOP_INST_DEF = 32'h0340_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_exc;
    logic [6:0]  cause;
  } fetch_entry_t;

  // An interrupt pending as the instruction enters the output slot outranks any fetch fault.
  function automatic fetch_entry_t tag_entry(input logic [31:0] pc,
                                             input logic [31:0] inst,
                                             input logic        is_exc,
                                             input logic [6:0]  cause,
                                             input logic        irq);
    fetch_entry_t e;
    e.pc     = pc;
    e.inst   = inst;
    e.is_exc = is_exc | irq;
    e.cause  = irq ? ECODE_INT : cause;
    return e;
  endfunction

endpackage

// File: rtl/pc_fetch_if_skid_buf.sv
// One-entry skid buffer catching a fetch response that arrives while ID holds the output slot.
module if_skid_buf
  import pc_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic         o_valid,
  output fetch_entry_t o_entry
);

  logic         r_valid;
  fetch_entry_t r_entry;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_entry <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_push) begin
      r_valid <= 1'b1;
      r_entry <= i_entry;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_entry = r_entry;

endmodule

// File: rtl/pc_fetch.sv
// LA32 PC and instruction-fetch stage: one outstanding SRAM-like request, redirect/pause
// handling, and a registered output slot with a 1-entry skid toward ID.
//
// state     | meaning
// IDLE      | no request; waiting for permission or for a redirect after ADEF
// REQ       | request presented at pc until inst_addr_ok (misaligned pc raises ADEF instead)
// WAIT      | request accepted; waiting for inst_data_ok
// DISCARD   | redirected while outstanding; drop the next response, pc holds new target
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause_pc,
  input  logic        pause_if,
  input  logic        exception_flush,
  input  logic [31:0] exception_in_pc,
  input  logic        is_interrupt,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_is_exception,
  output logic [6:0]  if_exception_cause
);

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic [31:0]  r_fly_pc;
  logic         r_adef_stall, w_adef_stall_nxt;
  logic         w_adef_fire;

  logic         r_if_valid;
  fetch_entry_t r_slot, w_slot_nxt;
  logic         w_slot_load;

  logic         w_skid_valid;
  fetch_entry_t w_skid_entry;
  fetch_entry_t w_resp_entry;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_slot_free;
  logic         w_misalign;
  logic         w_accept;
  logic         w_data_in;
  logic         w_perm;

  assign w_redirect = exception_flush | branch_flag;
  assign w_target   = exception_flush ? exception_in_pc : branch_target;
  assign w_slot_free = !r_if_valid || !pause_if;
  assign w_misalign = |r_pc[1:0];
  assign w_perm     = !pause_pc && (!w_skid_valid || w_slot_free);

  assign inst_req  = (r_state == S_REQ) && !w_misalign;
  assign inst_addr = r_pc;
  assign w_accept  = inst_req && inst_addr_ok;
  assign w_data_in = (r_state == S_WAIT) && inst_data_ok;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_adef_stall_nxt = r_adef_stall;
    w_adef_fire      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_redirect) begin
          w_pc_nxt         = w_target;
          w_adef_stall_nxt = 1'b0;
        end else if (!r_adef_stall && w_perm) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (w_accept) begin
          w_state_nxt = w_redirect ? S_DISCARD : S_WAIT;
          w_pc_nxt    = w_redirect ? w_target : r_pc + 32'd4;
        end else if (w_redirect) begin
          w_pc_nxt = w_target;
        end else if (w_misalign && w_slot_free && !w_skid_valid) begin
          w_adef_fire      = 1'b1;
          w_adef_stall_nxt = 1'b1;
          w_state_nxt      = S_IDLE;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_pc_nxt = w_target;
          // Response landing with the redirect is dropped right here; nothing left to discard.
          if (inst_data_ok) w_state_nxt = pause_pc ? S_IDLE : S_REQ;
          else              w_state_nxt = S_DISCARD;
        end else if (inst_data_ok) begin
          w_state_nxt = (!pause_pc && w_slot_free) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (w_redirect) w_pc_nxt = w_target;
        if (inst_data_ok) w_state_nxt = pause_pc ? S_IDLE : S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_fly_pc     <= '0;
      r_adef_stall <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_adef_stall <= w_adef_stall_nxt;
      if (w_accept) r_fly_pc <= r_pc;
    end
  end

  assign w_resp_entry = tag_entry(r_fly_pc, inst_rdata, 1'b0, ECODE_INT, 1'b0);

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_data_in && !w_redirect && !w_slot_free),
    .i_entry (w_resp_entry),
    .i_pop   (w_skid_valid && w_slot_free && !w_redirect),
    .i_flush (w_redirect),
    .o_valid (w_skid_valid),
    .o_entry (w_skid_entry)
  );

  // Skid is older than any in-flight response, so it drains first.
  always_comb begin
    w_slot_load = w_skid_valid || w_data_in || w_adef_fire;
    if (w_skid_valid)
      w_slot_nxt = tag_entry(w_skid_entry.pc, w_skid_entry.inst, w_skid_entry.is_exc,
                             w_skid_entry.cause, is_interrupt);
    else if (w_data_in)
      w_slot_nxt = tag_entry(r_fly_pc, inst_rdata, 1'b0, ECODE_INT, is_interrupt);
    else
      w_slot_nxt = tag_entry(r_pc, NOP_INST, 1'b1, ECODE_ADEF, is_interrupt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_valid <= 1'b0;
      r_slot     <= '0;
    end else if (w_redirect) begin
      r_if_valid <= 1'b0;
    end else if (w_slot_free) begin
      r_if_valid <= w_slot_load;
      if (w_slot_load) r_slot <= w_slot_nxt;
    end
  end

  assign if_valid           = r_if_valid;
  assign if_pc              = r_slot.pc;
  assign if_inst            = r_slot.inst;
  assign if_is_exception    = r_slot.is_exc;
  assign if_exception_cause = r_slot.cause;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: hand-driven bus handshakes with hand-computed expectations.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pause_pc = 1'b0, pause_if = 1'b0;
  logic        exception_flush = 1'b0;
  logic [31:0] exception_in_pc = '0;
  logic        is_interrupt = 1'b0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc, if_inst;
  logic        if_is_exception;
  logic [6:0]  if_exception_cause;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk(clk), .rst(rst), .pause_pc(pause_pc), .pause_if(pause_if),
    .exception_flush(exception_flush), .exception_in_pc(exception_in_pc),
    .is_interrupt(is_interrupt), .branch_flag(branch_flag), .branch_target(branch_target),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_is_exception(if_is_exception), .if_exception_cause(if_exception_cause)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_fetch(input logic [31:0] data);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = data;
    tick();
    inst_data_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_req",   32'(inst_req), 32'd0);
    chk("rst_addr",  inst_addr, 32'h1c00_0000);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc",    if_pc, 32'd0);
    chk("rst_inst",  if_inst, 32'd0);
    chk("rst_exc",   32'(if_is_exception), 32'd0);
    chk("rst_cause", 32'(if_exception_cause), 32'd0);
    tick();
    rst = 1'b1;

    // sequential fetch, back-to-back handshakes
    tick();
    chk("seq0_req",  32'(inst_req), 32'd1);
    chk("seq0_addr", inst_addr, 32'h1c00_0000);
    bus_fetch(32'hA000_0000);
    chk("seq0_valid", 32'(if_valid), 32'd1);
    chk("seq0_pc",    if_pc, 32'h1c00_0000);
    chk("seq0_inst",  if_inst, 32'hA000_0000);
    chk("seq1_addr",  inst_addr, 32'h1c00_0004);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    chk("seq_gap_valid", 32'(if_valid), 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hA000_0001;
    tick();
    inst_data_ok = 1'b0;
    chk("seq1_pc",   if_pc, 32'h1c00_0004);
    chk("seq2_addr", inst_addr, 32'h1c00_0008);

    // branch during WAIT for 1c000008
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    branch_flag = 1'b1; branch_target = 32'h1c00_0100;
    tick();
    branch_flag = 1'b0;
    chk("br_req",   32'(inst_req), 32'd0);
    chk("br_valid", 32'(if_valid), 32'd0);
    inst_data_ok = 1'b1; inst_rdata = 32'hA000_0002;
    tick();
    inst_data_ok = 1'b0;
    chk("br_drop_valid", 32'(if_valid), 32'd0);
    chk("br_req2",  32'(inst_req), 32'd1);
    chk("br_addr",  inst_addr, 32'h1c00_0100);
    bus_fetch(32'hB000_0000);
    chk("br_pc",    if_pc, 32'h1c00_0100);

    // skid fill while ID holds the slot
    pause_if = 1'b1;
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hB000_0001;
    tick();
    inst_data_ok = 1'b0;
    chk("skid_hold_valid", 32'(if_valid), 32'd1);
    chk("skid_hold_pc",    if_pc, 32'h1c00_0100);
    chk("skid_hold_inst",  if_inst, 32'hB000_0000);
    tick();
    chk("skid_noreq0", 32'(inst_req), 32'd0);
    tick();
    chk("skid_noreq1", 32'(inst_req), 32'd0);
    pause_if = 1'b0;
    tick();
    chk("skid_pc",    if_pc, 32'h1c00_0104);
    chk("skid_inst",  if_inst, 32'hB000_0001);
    chk("skid_valid", 32'(if_valid), 32'd1);
    chk("skid_req",   32'(inst_req), 32'd1);
    chk("skid_addr",  inst_addr, 32'h1c00_0108);

    // exception flush overrides both pauses
    pause_pc = 1'b1; pause_if = 1'b1;
    exception_flush = 1'b1; exception_in_pc = 32'h1c00_8000;
    tick();
    exception_flush = 1'b0;
    chk("fl_valid", 32'(if_valid), 32'd0);
    chk("fl_addr",  inst_addr, 32'h1c00_8000);
    pause_pc = 1'b0; pause_if = 1'b0;
    bus_fetch(32'hC000_0000);
    chk("fl_pc",   if_pc, 32'h1c00_8000);
    chk("fl_inst", if_inst, 32'hC000_0000);

    // retarget REQ before accept, then interrupt tag on one instruction
    branch_flag = 1'b1; branch_target = 32'h1c00_0010;
    tick();
    branch_flag = 1'b0;
    chk("rt_addr",  inst_addr, 32'h1c00_0010);
    chk("rt_valid", 32'(if_valid), 32'd0);
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1; inst_rdata = 32'hD000_0000; is_interrupt = 1'b1;
    tick();
    inst_data_ok = 1'b0; is_interrupt = 1'b0;
    chk("int_pc",    if_pc, 32'h1c00_0010);
    chk("int_exc",   32'(if_is_exception), 32'd1);
    chk("int_cause", 32'(if_exception_cause), 32'h00);
    bus_fetch(32'hD000_0001);
    chk("int_next_pc",  if_pc, 32'h1c00_0014);
    chk("int_next_exc", 32'(if_is_exception), 32'd0);

    // ADEF on misaligned target
    branch_flag = 1'b1; branch_target = 32'h1c00_0102;
    tick();
    branch_flag = 1'b0;
    chk("adef_noreq", 32'(inst_req), 32'd0);
    tick();
    chk("adef_valid", 32'(if_valid), 32'd1);
    chk("adef_pc",    if_pc, 32'h1c00_0102);
    chk("adef_inst",  if_inst, 32'h0340_0000);
    chk("adef_exc",   32'(if_is_exception), 32'd1);
    chk("adef_cause", 32'(if_exception_cause), 32'h08);
    tick();
    chk("adef_stall_req",   32'(inst_req), 32'd0);
    chk("adef_stall_valid", 32'(if_valid), 32'd0);

    // interrupt outranks ADEF
    branch_flag = 1'b1; branch_target = 32'h1c00_0106;
    tick();
    branch_flag = 1'b0; is_interrupt = 1'b1;
    tick();
    tick();
    is_interrupt = 1'b0;
    chk("intadef_pc",    if_pc, 32'h1c00_0106);
    chk("intadef_exc",   32'(if_is_exception), 32'd1);
    chk("intadef_cause", 32'(if_exception_cause), 32'h00);

    // pc+4 wraps
    branch_flag = 1'b1; branch_target = 32'hffff_fffc;
    tick();
    branch_flag = 1'b0;
    tick();
    chk("wrap_addr0", inst_addr, 32'hffff_fffc);
    bus_fetch(32'hE000_0000);
    chk("wrap_pc",    if_pc, 32'hffff_fffc);
    chk("wrap_addr1", inst_addr, 32'h0000_0000);
    chk("wrap_req",   32'(inst_req), 32'd1);

    // async reset with a request outstanding; late response ignored
    inst_addr_ok = 1'b1;
    tick();
    inst_addr_ok = 1'b0;
    rst = 1'b0;
    #2;
    chk("arst_req",   32'(inst_req), 32'd0);
    chk("arst_addr",  inst_addr, 32'h1c00_0000);
    chk("arst_valid", 32'(if_valid), 32'd0);
    pause_pc = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    inst_data_ok = 1'b1; inst_rdata = 32'hF000_0000;
    tick();
    inst_data_ok = 1'b0;
    chk("late_valid", 32'(if_valid), 32'd0);
    chk("late_req",   32'(inst_req), 32'd0);
    pause_pc = 1'b0;
    tick();
    chk("rel_req",  32'(inst_req), 32'd1);
    chk("rel_addr", inst_addr, 32'h1c00_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Program-counter and instruction-fetch stage of the LA32 pipeline, feeding the ID stage. It holds the PC and issues one-outstanding-request fetches on the instruction SRAM-like bus. It applies the pause, flush, redirect and interrupt indications produced by the pipeline controller and ID-stage branches. Each fetched instruction is delivered to ID with its PC and any fetch-side exception tag.

Parameters:
RESET_PC, 32'h1c00_0000, first fetch address after reset release
NOP_INST, 32'h0340_0000, instruction word delivered when no real fetch occurs (ADEF)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset (0 = reset)
pause_pc  in  1  pause[0] from controller; freeze PC / no new request
pause_if  in  1  pause[1] from controller; ID not accepting; hold output
exception_flush  in  1  exception or ertn at MEM; redirect to exception_in_pc
exception_in_pc  in  32  redirect target (EENTRY or ERA)
is_interrupt  in  1  pending enabled interrupt
branch_flag  in  1  taken branch/jump resolved in ID
branch_target  in  32  branch destination
inst_req  out  1  bus request valid
inst_addr  out  32  bus request address
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  read data valid this cycle
inst_rdata  in  32  read data
if_valid  out  1  output slot holds an instruction for ID
if_pc  out  32  its PC
if_inst  out  32  its instruction word
if_is_exception  out  1  instruction carries a fetch-side exception
if_exception_cause  out  7  Ecode: INT 7'h00, ADEF 7'h08

Behaviour:
- Reset: inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_is_exception=0, if_exception_cause=7'h00. FSM=IDLE, skid empty, pc=RESET_PC.
- FSM states: IDLE, REQ, WAIT, DISCARD.
- IDLE -> REQ on the first cycle out of reset when pause_pc=0 and the output slot can accept.
- REQ: inst_req=1, inst_addr=pc, both held stable until inst_addr_ok. On accept: -> WAIT, pc <= pc+4.
- WAIT: on inst_data_ok, the word goes to the output slot, or to the skid if the slot is held. Then -> REQ if a new request is permitted, else IDLE.
- Permission for a new request: pause_pc=0, and the skid is empty or will drain this cycle. Never more than one request outstanding.
- Redirect priority: exception_flush > branch_flag > sequential. A redirect loads pc with the target.
  - In IDLE or REQ-before-accept, the redirect takes effect the same cycle. REQ may retarget only before inst_addr_ok.
  - In WAIT, or in REQ with inst_addr_ok in the same cycle, the redirect target is latched and FSM -> DISCARD.
  - DISCARD waits for inst_data_ok and drops that data, then -> REQ at the latched target.
  - A later redirect arriving in DISCARD overwrites the latched target.
- exception_flush also clears if_valid and the skid in the same cycle. It overrides pause_pc and pause_if.
- branch_flag clears if_valid/skid only for instructions younger than the branch, i.e. anything in the slot or skid.
- Output slot: updates only when pause_if=0 or if_valid=0. If pause_if=1 and if_valid=1, all if_* outputs hold. The skid (1 entry) drains to the slot on the first cycle pause_if=0.
- ADEF: if pc[1:0]!=0 at issue time, no bus request is made. The slot receives if_pc=pc, if_inst=NOP_INST, if_is_exception=1, cause 7'h08. FSM -> IDLE and fetch stalls until a redirect.
- Interrupt: when is_interrupt=1 as an instruction enters the slot, it is tagged if_is_exception=1, cause 7'h00. INT has priority over ADEF.
- Delivery latency: addr_ok and data_ok in consecutive cycles give one instruction per 2 cycles minimum, with if_valid registered 1 cycle after data_ok.
- pc+4 wraps modulo 2^32.
- Asynchronous reset mid-transaction: all state is cleared. Any bus response arriving after release while in IDLE is ignored.

Decomposition:
- Shared define file gets: ECODE_INT (7'h00), ECODE_ADEF (7'h08), NOP_INST, RESET_PC default, and the FSM state encodings.
- One sub-module is natural: if_skid_buf, the 1-entry buffer holding {pc, inst, is_exception, cause} with push/pop/flush.

Test Plan:
- Reset release, bus responds addr_ok/data_ok back-to-back -> inst_addr 1c000000, 1c000004, 1c000008; if_pc follows in order; if_valid pulses every 2 cycles.
- branch_flag=1, target 1c000100, asserted during WAIT for 1c000008 -> that data dropped; next inst_addr=1c000100; no if_valid for 1c000008.
- exception_flush=1, exception_in_pc=1c008000, while pause_pc=pause_if=1 -> if_valid=0 next cycle; next request at 1c008000.
- pause_if=1 with if_valid=1 and data_ok arriving -> if_* unchanged; skid filled; pause_if=0 -> skid word appears next cycle; no further request was issued while the skid was full.
- Redirect to 1c000102 -> no inst_req; if_pc=1c000102, if_inst=03400000, if_is_exception=1, cause=08.
- is_interrupt=1 during fetch of 1c000010 -> if_is_exception=1, cause=00 on that instruction only.
